// File: rtl/axil_ram_arb2.sv
// axil_ram_arb2: 2:1 AXI-Lite arbiter sharing one AXI-Lite slave between two masters.
// Write and read paths are arbitrated independently. Each path carries at most one
// transaction, and ties are resolved round-robin per path.
// Optional build macro AXIL_ARB_FIXED_PRIO_EN selects fixed priority (master 0 > master 1).
// With the macro defined, the round-robin pointers are not built.
// All channel muxes are combinational from the registered grant and state.
// Nothing is buffered; the only added latency is the one-cycle IDLE->ADDR arbitration bubble.
module axil_ram_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0
    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic [2:0]            s0_axil_awprot,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
    input  logic [2:0]            s0_axil_arprot,
    input  logic                  s0_axil_arvalid,
    output logic                  s0_axil_arready,
    output logic [DATA_WIDTH-1:0] s0_axil_rdata,
    output logic [1:0]            s0_axil_rresp,
    output logic                  s0_axil_rvalid,
    input  logic                  s0_axil_rready,
    // master 1
    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic [2:0]            s1_axil_awprot,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
    input  logic [2:0]            s1_axil_arprot,
    input  logic                  s1_axil_arvalid,
    output logic                  s1_axil_arready,
    output logic [DATA_WIDTH-1:0] s1_axil_rdata,
    output logic [1:0]            s1_axil_rresp,
    output logic                  s1_axil_rvalid,
    input  logic                  s1_axil_rready,
    // shared slave
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [1:0] w_state_r, w_state_nxt_s;
    logic       wg_r, wg_nxt_s;
    logic       aw_done_r, aw_done_nxt_s;
    logic       w_done_r, w_done_nxt_s;
    logic [1:0] r_state_r, r_state_nxt_s;
    logic       rg_r, rg_nxt_s;

    logic       w_pick_s, r_pick_s;
    logic       aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    assign aw_hs_s = m_axil_awvalid & m_axil_awready;
    assign w_hs_s  = m_axil_wvalid & m_axil_wready;
    assign b_hs_s  = m_axil_bvalid & m_axil_bready;
    assign ar_hs_s = m_axil_arvalid & m_axil_arready;
    assign r_hs_s  = m_axil_rvalid & m_axil_rready;

`ifdef AXIL_ARB_FIXED_PRIO_EN
    // master 0 always wins when it requests
    assign w_pick_s = ~s0_axil_awvalid;
    assign r_pick_s = ~s0_axil_arvalid;
`else
    logic w_last_r, r_last_r;

    // on a tie the master that was not granted last wins; a lone requester always wins
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        logic pick;
        if (req0 && req1) begin
            pick = ~last;
        end else if (req0) begin
            pick = 1'b0;
        end else begin
            pick = 1'b1;
        end
        return pick;
    endfunction

    assign w_pick_s = rr_pick(s0_axil_awvalid, s1_axil_awvalid, w_last_r);
    assign r_pick_s = rr_pick(s0_axil_arvalid, s1_axil_arvalid, r_last_r);

    // round-robin pointers record the master of the last completed transaction per path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_last_r <= 1'b1;
            r_last_r <= 1'b1;
        end else begin
            if (w_state_r == W_RESP && b_hs_s) begin
                w_last_r <= wg_r;
            end
            if (r_state_r == R_DATA && r_hs_s) begin
                r_last_r <= rg_r;
            end
        end
    end
`endif

    // write path next-state: grant, then collect AW and W handshakes in any order, then B
    always_comb begin
        w_state_nxt_s = w_state_r;
        wg_nxt_s      = wg_r;
        aw_done_nxt_s = aw_done_r;
        w_done_nxt_s  = w_done_r;
        case (w_state_r)
            W_IDLE: begin
                if (s0_axil_awvalid || s1_axil_awvalid) begin
                    wg_nxt_s      = w_pick_s;
                    w_state_nxt_s = W_ADDR;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_ADDR: begin
                if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                    w_state_nxt_s = W_RESP;
                    aw_done_nxt_s = 1'b0;
                    w_done_nxt_s  = 1'b0;
                end else begin
                    aw_done_nxt_s = aw_done_r | aw_hs_s;
                    w_done_nxt_s  = w_done_r | w_hs_s;
                end
            end
            W_RESP: begin
                if (b_hs_s) begin
                    w_state_nxt_s = W_IDLE;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
                aw_done_nxt_s = 1'b0;
                w_done_nxt_s  = 1'b0;
            end
        endcase
    end

    // read path next-state: grant, forward AR, wait for the R handshake
    always_comb begin
        r_state_nxt_s = r_state_r;
        rg_nxt_s      = rg_r;
        case (r_state_r)
            R_IDLE: begin
                if (s0_axil_arvalid || s1_axil_arvalid) begin
                    rg_nxt_s      = r_pick_s;
                    r_state_nxt_s = R_ADDR;
                end else begin
                    r_state_nxt_s = R_IDLE;
                end
            end
            R_ADDR: begin
                if (ar_hs_s) begin
                    r_state_nxt_s = R_DATA;
                end else begin
                    r_state_nxt_s = R_ADDR;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    r_state_nxt_s = R_IDLE;
                end else begin
                    r_state_nxt_s = R_DATA;
                end
            end
            default: begin
                r_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // state, grant and handshake-tracking registers for both paths
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_r <= W_IDLE;
            wg_r      <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            r_state_r <= R_IDLE;
            rg_r      <= 1'b0;
        end else begin
            w_state_r <= w_state_nxt_s;
            wg_r      <= wg_nxt_s;
            aw_done_r <= aw_done_nxt_s;
            w_done_r  <= w_done_nxt_s;
            r_state_r <= r_state_nxt_s;
            rg_r      <= rg_nxt_s;
        end
    end

    // write channel routing; everything outside the owning state or grant is held at zero
    always_comb begin
        m_axil_awaddr   = {ADDR_WIDTH{1'b0}};
        m_axil_awprot   = 3'b000;
        m_axil_awvalid  = 1'b0;
        m_axil_wdata    = {DATA_WIDTH{1'b0}};
        m_axil_wstrb    = {STRB_WIDTH{1'b0}};
        m_axil_wvalid   = 1'b0;
        m_axil_bready   = 1'b0;
        s0_axil_awready = 1'b0;
        s1_axil_awready = 1'b0;
        s0_axil_wready  = 1'b0;
        s1_axil_wready  = 1'b0;
        s0_axil_bvalid  = 1'b0;
        s1_axil_bvalid  = 1'b0;
        s0_axil_bresp   = 2'b00;
        s1_axil_bresp   = 2'b00;
        if (w_state_r == W_ADDR) begin
            m_axil_awaddr   = wg_r ? s1_axil_awaddr : s0_axil_awaddr;
            m_axil_awprot   = wg_r ? s1_axil_awprot : s0_axil_awprot;
            m_axil_awvalid  = ~aw_done_r & (wg_r ? s1_axil_awvalid : s0_axil_awvalid);
            m_axil_wdata    = wg_r ? s1_axil_wdata : s0_axil_wdata;
            m_axil_wstrb    = wg_r ? s1_axil_wstrb : s0_axil_wstrb;
            m_axil_wvalid   = ~w_done_r & (wg_r ? s1_axil_wvalid : s0_axil_wvalid);
            s0_axil_awready = ~wg_r & ~aw_done_r & m_axil_awready;
            s1_axil_awready =  wg_r & ~aw_done_r & m_axil_awready;
            s0_axil_wready  = ~wg_r & ~w_done_r & m_axil_wready;
            s1_axil_wready  =  wg_r & ~w_done_r & m_axil_wready;
        end else if (w_state_r == W_RESP) begin
            m_axil_bready  = wg_r ? s1_axil_bready : s0_axil_bready;
            s0_axil_bvalid = ~wg_r & m_axil_bvalid;
            s1_axil_bvalid =  wg_r & m_axil_bvalid;
            s0_axil_bresp  = wg_r ? 2'b00 : m_axil_bresp;
            s1_axil_bresp  = wg_r ? m_axil_bresp : 2'b00;
        end else begin
            m_axil_awvalid = 1'b0;
        end
    end

    // read channel routing; everything outside the owning state or grant is held at zero
    always_comb begin
        m_axil_araddr   = {ADDR_WIDTH{1'b0}};
        m_axil_arprot   = 3'b000;
        m_axil_arvalid  = 1'b0;
        m_axil_rready   = 1'b0;
        s0_axil_arready = 1'b0;
        s1_axil_arready = 1'b0;
        s0_axil_rvalid  = 1'b0;
        s1_axil_rvalid  = 1'b0;
        s0_axil_rdata   = {DATA_WIDTH{1'b0}};
        s1_axil_rdata   = {DATA_WIDTH{1'b0}};
        s0_axil_rresp   = 2'b00;
        s1_axil_rresp   = 2'b00;
        if (r_state_r == R_ADDR) begin
            m_axil_araddr   = rg_r ? s1_axil_araddr : s0_axil_araddr;
            m_axil_arprot   = rg_r ? s1_axil_arprot : s0_axil_arprot;
            m_axil_arvalid  = rg_r ? s1_axil_arvalid : s0_axil_arvalid;
            s0_axil_arready = ~rg_r & m_axil_arready;
            s1_axil_arready =  rg_r & m_axil_arready;
        end else if (r_state_r == R_DATA) begin
            m_axil_rready  = rg_r ? s1_axil_rready : s0_axil_rready;
            s0_axil_rvalid = ~rg_r & m_axil_rvalid;
            s1_axil_rvalid =  rg_r & m_axil_rvalid;
            s0_axil_rdata  = rg_r ? {DATA_WIDTH{1'b0}} : m_axil_rdata;
            s1_axil_rdata  = rg_r ? m_axil_rdata : {DATA_WIDTH{1'b0}};
            s0_axil_rresp  = rg_r ? 2'b00 : m_axil_rresp;
            s1_axil_rresp  = rg_r ? m_axil_rresp : 2'b00;
        end else begin
            m_axil_arvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_ram_arb2.sv
// Testbench for axil_ram_arb2: a behavioural AXI-Lite RAM acts as the shared slave,
// and per-master scoreboards hold the expected B/R responses.
module tb_axil_ram_arb2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // master-side stimulus (index = master number)
    logic [15:0] awaddr [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic [15:0] araddr [2];
    logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
    // master-side DUT outputs
    logic [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp [2];
    logic [1:0]  s_rresp [2];
    logic [31:0] s_rdata [2];
    // slave side
    logic [15:0] m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    axil_ram_arb2 dut (
        .clk(clk), .rst(rst),
        .s0_axil_awaddr(awaddr[0]), .s0_axil_awprot(3'b000), .s0_axil_awvalid(awvalid[0]), .s0_axil_awready(s_awready[0]),
        .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(wstrb[0]), .s0_axil_wvalid(wvalid[0]), .s0_axil_wready(s_wready[0]),
        .s0_axil_bresp(s_bresp[0]), .s0_axil_bvalid(s_bvalid[0]), .s0_axil_bready(bready[0]),
        .s0_axil_araddr(araddr[0]), .s0_axil_arprot(3'b000), .s0_axil_arvalid(arvalid[0]), .s0_axil_arready(s_arready[0]),
        .s0_axil_rdata(s_rdata[0]), .s0_axil_rresp(s_rresp[0]), .s0_axil_rvalid(s_rvalid[0]), .s0_axil_rready(rready[0]),
        .s1_axil_awaddr(awaddr[1]), .s1_axil_awprot(3'b000), .s1_axil_awvalid(awvalid[1]), .s1_axil_awready(s_awready[1]),
        .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(wstrb[1]), .s1_axil_wvalid(wvalid[1]), .s1_axil_wready(s_wready[1]),
        .s1_axil_bresp(s_bresp[1]), .s1_axil_bvalid(s_bvalid[1]), .s1_axil_bready(bready[1]),
        .s1_axil_araddr(araddr[1]), .s1_axil_arprot(3'b000), .s1_axil_arvalid(arvalid[1]), .s1_axil_arready(s_arready[1]),
        .s1_axil_rdata(s_rdata[1]), .s1_axil_rresp(s_rresp[1]), .s1_axil_rvalid(s_rvalid[1]), .s1_axil_rready(rready[1]),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready)
    );

    // ---------------- behavioural slave RAM (addresses 0xFxxx answer SLVERR) ----------------
    bit   [31:0] mem [256];
    logic        aw_got, w_got;
    logic [15:0] aw_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;

    assign m_awready = ~aw_got;
    assign m_wready  = ~w_got;
    assign m_arready = ~m_rvalid;

    // slave: accept AW and W independently, answer B once both arrived, answer R one cycle after AR
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_a <= 16'h0000; w_d <= 32'h0; w_s <= 4'h0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00; m_rvalid <= 1'b0; m_rdata <= 32'h0; m_rresp <= 2'b00;
        end else begin
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
            if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
            if (aw_got && w_got && !m_bvalid) begin
                m_bvalid <= 1'b1;
                m_bresp  <= (aw_a[15:12] == 4'hF) ? 2'b10 : 2'b00;
                if (aw_a[15:12] != 4'hF) begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_s[i]) mem[aw_a[9:2]][8*i +: 8] <= w_d[8*i +: 8];
                    end
                end
            end
            if (m_bvalid && m_bready) begin m_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= (m_araddr[15:12] == 4'hF) ? 32'h0 : mem[m_araddr[9:2]];
                m_rresp  <= (m_araddr[15:12] == 4'hF) ? 2'b10 : 2'b00;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
        end
    end

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int errors = 0;
    logic [1:0]  bq [2][$];
    logic [33:0] rq [2][$];
    int          order_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm, input int m);
        checks++;
        errors++;
        $display("FAIL %s (master %0d): handshake never seen, got timeout expected handshake", nm, m);
    endtask

    function automatic logic any_out();
        return |{s_awready, s_wready, s_bvalid, s_bresp[0], s_bresp[1], s_arready, s_rvalid,
                 s_rdata[0], s_rdata[1], s_rresp[0], s_rresp[1], m_awvalid, m_awaddr, m_awprot,
                 m_wvalid, m_wdata, m_wstrb, m_bready, m_arvalid, m_araddr, m_arprot, m_rready};
    endfunction

    // full write: AW and W raised together, B popped against the scoreboard; n = negedges until AW accepted
    task automatic wr(input int m, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] er, output int n_aw);
        bit aw_ok = 0, w_ok = 0, got = 0, hs_aw, hs_w;
        int n = 0;
        logic [1:0] e;
        bq[m].push_back(er);
        awaddr[m] = a; wdata[m] = d; wstrb[m] = s;
        awvalid[m] = 1'b1; wvalid[m] = 1'b1; bready[m] = 1'b1;
        n_aw = 0;
        while (!(aw_ok && w_ok) && n < 100) begin
            @(negedge clk); n++;
            hs_aw = awvalid[m] && s_awready[m];
            hs_w  = wvalid[m] && s_wready[m];
            if (hs_aw) begin n_aw = n; order_q.push_back(m); end
            @(posedge clk); #1;
            if (hs_aw) begin awvalid[m] = 1'b0; aw_ok = 1; end
            if (hs_w) begin wvalid[m] = 1'b0; w_ok = 1; end
        end
        if (!(aw_ok && w_ok)) tmo("aw_w_timeout", m);
        n = 0;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            if (s_bvalid[m] && bready[m]) begin
                got = 1;
                e = bq[m].pop_front();
                chk("bresp", {62'd0, s_bresp[m]}, {62'd0, e});
            end
            @(posedge clk); #1;
        end
        bready[m] = 1'b0;
        awvalid[m] = 1'b0; wvalid[m] = 1'b0;
        if (!got) tmo("b_timeout", m);
    endtask

    task automatic issue_ar(input int m, input logic [15:0] a, output int n_ar);
        bit ok = 0, hs;
        int n = 0;
        araddr[m] = a; arvalid[m] = 1'b1; n_ar = 0;
        while (!ok && n < 100) begin
            @(negedge clk); n++;
            hs = arvalid[m] && s_arready[m];
            if (hs) n_ar = n;
            @(posedge clk); #1;
            if (hs) begin arvalid[m] = 1'b0; ok = 1; end
        end
        arvalid[m] = 1'b0;
        if (!ok) tmo("ar_timeout", m);
    endtask

    task automatic wait_r(input int m);
        bit got = 0;
        int n = 0;
        logic [33:0] e;
        rready[m] = 1'b1;
        while (!got && n < 100) begin
            @(negedge clk); n++;
            if (s_rvalid[m] && rready[m]) begin
                got = 1;
                e = rq[m].pop_front();
                chk("rdata", {32'd0, s_rdata[m]}, {32'd0, e[31:0]});
                chk("rresp", {62'd0, s_rresp[m]}, {62'd0, e[33:32]});
            end
            @(posedge clk); #1;
        end
        rready[m] = 1'b0;
        if (!got) tmo("r_timeout", m);
    endtask

    task automatic rd(input int m, input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er,
                      output int n_ar);
        rq[m].push_back({er, ed});
        issue_ar(m, a, n_ar);
        wait_r(m);
    endtask

    task automatic tie(input string nm, input logic [15:0] a0, input logic [15:0] a1, input int first);
        int n0, n1;
        order_q.delete();
        fork
            wr(0, a0, {2{a0}}, 4'hF, 2'b00, n0);
            wr(1, a1, {2{a1}}, 4'hF, 2'b00, n1);
        join
        chk({nm, "_grants"}, order_q.size(), 2);
        if (order_q.size() == 2) begin
            chk({nm, "_first"}, order_q[0], first);
            chk({nm, "_second"}, order_q[1], 1 - first);
        end
    endtask

    typedef struct {
        bit          wr;
        int          m;
        logic [15:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [1:0]  resp;   // expected bresp / rresp
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n, n2;
        int tie2_first;

        tbl[0]  = '{1'b1, 1, 16'h0080, 32'h11223344, 4'hF, 2'b00};
        tbl[1]  = '{1'b0, 0, 16'h0080, 32'h11223344, 4'hF, 2'b00};
        tbl[2]  = '{1'b1, 0, 16'h0080, 32'hAABBCCDD, 4'h3, 2'b00};
        tbl[3]  = '{1'b0, 1, 16'h0080, 32'h1122CCDD, 4'hF, 2'b00};
        tbl[4]  = '{1'b1, 1, 16'h0084, 32'hCAFEF00D, 4'hF, 2'b00};
        tbl[5]  = '{1'b1, 0, 16'h0084, 32'h55667788, 4'hC, 2'b00};
        tbl[6]  = '{1'b0, 0, 16'h0084, 32'h5566F00D, 4'hF, 2'b00};
        tbl[7]  = '{1'b0, 1, 16'h0088, 32'h00000000, 4'hF, 2'b00};
        tbl[8]  = '{1'b1, 0, 16'hF000, 32'h12345678, 4'hF, 2'b10};
        tbl[9]  = '{1'b0, 1, 16'hF000, 32'h00000000, 4'hF, 2'b10};
        tbl[10] = '{1'b1, 1, 16'h0044, 32'h0BADF00D, 4'hF, 2'b00};
        tbl[11] = '{1'b0, 0, 16'h0044, 32'h0BADF00D, 4'hF, 2'b00};
`ifdef AXIL_ARB_FIXED_PRIO_EN
        tie2_first = 0;
`else
        tie2_first = 1;
`endif

        for (int i = 0; i < 2; i++) begin
            awaddr[i] = 16'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0; araddr[i] = 16'h0;
        end
        awvalid = 2'b00; wvalid = 2'b00; bready = 2'b00; arvalid = 2'b00; rready = 2'b00;

        // reset: outputs stay zero even with requests pending
        rst = 1'b1;
        awvalid[0] = 1'b1; arvalid[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs_zero", {63'd0, any_out()}, 64'd0);
        awvalid = 2'b00; arvalid = 2'b00;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // tie right after reset: master 0 first
        tie("tie1", 16'h0020, 16'h0024, 0);

        // single write from s0, one-cycle arbitration bubble, then read back
        wr(0, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, n);
        chk("aw_latency", n, 2);
        rd(0, 16'h0010, 32'hDEADBEEF, 2'b00, n);
        chk("ar_latency", n, 2);

        // s0 was granted last on the write path, so s1 wins this tie (round-robin)
        tie("tie2", 16'h0028, 16'h002C, tie2_first);

        // table-driven transactions
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) wr(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, n);
            else           rd(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].resp, n);
        end
        rd(1, 16'h0024, 32'h00240024, 2'b00, n);

        // W ahead of AW: wready stays low until s1 is granted
        wdata[1] = 32'h5A5AA5A5; wstrb[1] = 4'hF; wvalid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) chk("early_wready", {63'd0, s_wready[1]}, 64'd0);
            @(posedge clk); #1;
        end
        wr(1, 16'h0050, 32'h5A5AA5A5, 4'hF, 2'b00, n);
        rd(0, 16'h0050, 32'h5A5AA5A5, 2'b00, n);

        // concurrent write (s0) and read (s1): each sees only the arbitration bubble
        fork
            wr(0, 16'h0040, 32'h40404040, 4'hF, 2'b00, n);
            rd(1, 16'h0044, 32'h0BADF00D, 2'b00, n2);
        join
        chk("conc_aw_latency", n, 2);
        chk("conc_ar_latency", n2, 2);
        rd(1, 16'h0040, 32'h40404040, 2'b00, n);

        // R backpressure on s0 while s1 waits for the read path
        rq[0].push_back({2'b00, 32'hDEADBEEF});
        issue_ar(0, 16'h0010, n);
        araddr[1] = 16'h0020; arvalid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rvalid", {63'd0, s_rvalid[0]}, 64'd1);
            chk("bp_rdata", {32'd0, s_rdata[0]}, {32'd0, 32'hDEADBEEF});
            chk("bp_s1_arready", {63'd0, s_arready[1]}, 64'd0);
            @(posedge clk); #1;
        end
        wait_r(0);
        rd(1, 16'h0020, 32'h00200020, 2'b00, n);

        // async reset after the AW handshake but before W
        awaddr[0] = 16'h0060; awvalid[0] = 1'b1;
        n = 0;
        while (awvalid[0] && n < 100) begin
            @(negedge clk); n++;
            n2 = int'(s_awready[0]);
            @(posedge clk); #1;
            if (n2 == 1) awvalid[0] = 1'b0;
        end
        if (awvalid[0]) tmo("abort_aw_timeout", 0);
        awvalid[0] = 1'b0;
        rst = 1'b1;
        #1 chk("midreset_outputs_zero", {63'd0, any_out()}, 64'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) chk("post_reset_idle", {63'd0, any_out()}, 64'd0);
        @(posedge clk); #1;
        tie("tie3", 16'h0030, 16'h0034, 0);
        rd(1, 16'h0060, 32'h00000000, 2'b00, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
